// File: rtl/vidas_ctrl.sv
// Player-lives sequencer: IDLE/PLAY/COOLDOWN/OVER FSM with a frame-synchronous lives display; VIDAS_BLINK_EN adds cooldown icon blinking.
// Latency: state/flags update on the event edge; vidas updates on the next frame_tick edge.
// Backpressure: none, all inputs are single-cycle pulses consumed or ignored on the cycle they arrive.
module vidas_ctrl #(
  parameter int MAX_VIDAS       = 7,
  parameter int INIT_VIDAS      = 3,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int BLINK_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       bonus,
  input  logic       frame_tick,
  output logic [2:0] vidas,
  output logic       invuln,
  output logic       game_over,
  output logic [1:0] state
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PLAY     = 2'b01,
    COOLDOWN = 2'b10,
    OVER     = 2'b11
  } state_t;

  state_t        state_q, state_nxt;
  logic [2:0]    lives_reg, lives_nxt;
  logic [CW-1:0] cd_cnt, cd_nxt;
  logic [2:0]    vidas_nxt;
  logic          invuln_nxt, game_over_nxt;
  logic          blink_hide;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'(MAX_VIDAS)) ? v : v + 3'd1;
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lives_reg <= 3'(INIT_VIDAS);
      cd_cnt    <= '0;
      vidas     <= 3'd0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      lives_reg <= lives_nxt;
      cd_cnt    <= cd_nxt;
      vidas     <= vidas_nxt;
      invuln    <= invuln_nxt;
      game_over <= game_over_nxt;
    end
  end

  // Next state, lives and cooldown counter
  always_comb begin
    state_nxt = state_q;
    lives_nxt = lives_reg;
    cd_nxt    = cd_cnt;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = PLAY;
          lives_nxt = 3'(INIT_VIDAS);
        end
      end
      PLAY: begin
        // hit has priority; a simultaneous bonus is dropped
        if (hit) begin
          if (lives_reg <= 3'd1) begin
            lives_nxt = 3'd0;
            state_nxt = OVER;
          end else begin
            lives_nxt = lives_reg - 3'd1;
            state_nxt = COOLDOWN;
            cd_nxt    = CW'(COOLDOWN_FRAMES);
          end
        end else if (bonus) begin
          lives_nxt = sat_inc(lives_reg);
        end
      end
      COOLDOWN: begin
        if (bonus) lives_nxt = sat_inc(lives_reg);
        if (frame_tick && (cd_cnt != '0)) begin
          cd_nxt = cd_cnt - CW'(1);
          if (cd_cnt == CW'(1)) state_nxt = PLAY;
        end
      end
      OVER: begin
        if (start) begin
          state_nxt = PLAY;
          lives_nxt = 3'(INIT_VIDAS);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output next values; vidas samples pre-event lives only on frame_tick
  always_comb begin
    invuln_nxt    = (state_nxt == COOLDOWN);
    game_over_nxt = (state_nxt == OVER);
    vidas_nxt     = vidas;
    if (frame_tick)
      vidas_nxt = ((state_q == IDLE) || blink_hide) ? 3'd0 : lives_reg;
  end

`ifdef VIDAS_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  // Phase only runs while staying in COOLDOWN, so entry and exit both clear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if ((state_q == COOLDOWN) && (state_nxt == COOLDOWN)) begin
      if (frame_tick) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end else begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end
  end

  assign blink_hide = (state_q == COOLDOWN) && blink_ph;
`else
  logic unused_blink;
  assign unused_blink = (BLINK_FRAMES > 0);
  assign blink_hide   = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_vidas_ctrl.sv
// Directed plus randomized bench for vidas_ctrl against a frame/lives reference model.
module tb_vidas_ctrl;

  localparam int MAXV  = 7;
  localparam int INITV = 3;
  localparam int CDF   = 60;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_COOL = 2;
  localparam int M_OVER = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, hit, bonus, frame_tick;
  logic [2:0] vidas;
  logic       invuln, game_over;
  logic [1:0] state;

  int m_mode, m_lives, m_left, m_disp;
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  vidas_ctrl #(
    .MAX_VIDAS(MAXV),
    .INIT_VIDAS(INITV),
    .COOLDOWN_FRAMES(CDF),
    .BLINK_FRAMES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .hit(hit),
    .bonus(bonus),
    .frame_tick(frame_tick),
    .vidas(vidas),
    .invuln(invuln),
    .game_over(game_over),
    .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_lives = INITV;
    m_left  = 0;
    m_disp  = 0;
  endtask

  // One clock of game rules: display grabs the pre-event count, then events apply
  task automatic model_step(input bit s, input bit h, input bit b, input bit t);
    int nm, nl, nleft;
    nm = m_mode; nl = m_lives; nleft = m_left;
    if (t) m_disp = (m_mode == M_IDLE) ? 0 : m_lives;
    case (m_mode)
      M_IDLE: if (s) begin nm = M_PLAY; nl = INITV; end
      M_PLAY: begin
        if (h) begin
          nl = m_lives - 1;
          if (nl == 0) nm = M_OVER;
          else begin nm = M_COOL; nleft = CDF; end
        end else if (b) begin
          nl = (m_lives + 1 > MAXV) ? MAXV : m_lives + 1;
        end
      end
      M_COOL: begin
        if (b) nl = (m_lives + 1 > MAXV) ? MAXV : m_lives + 1;
        if (t) begin
          nleft = m_left - 1;
          if (nleft == 0) nm = M_PLAY;
        end
      end
      default: if (s) begin nm = M_PLAY; nl = INITV; end
    endcase
    m_mode = nm; m_lives = nl; m_left = nleft;
  endtask

  task automatic check_model();
    chk("state", state, m_mode);
    chk("vidas", vidas, m_disp);
    chk("invuln", invuln, (m_mode == M_COOL));
    chk("game_over", game_over, (m_mode == M_OVER));
  endtask

  task automatic cyc(input bit s, input bit h, input bit b, input bit t);
    start = s; hit = h; bonus = b; frame_tick = t;
    @(posedge clk);
    model_step(s, h, b, t);
    #1;
    start = 1'b0; hit = 1'b0; bonus = 1'b0; frame_tick = 1'b0;
    check_model();
  endtask

  task automatic finish_cd();
    for (int i = 0; i < 100 && state != 2'b01; i++) cyc(0, 0, 0, 1);
    chk("cd_exit_state", state, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; bonus = 1'b0; frame_tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    // Some activity, then a reset between edges
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_state", state, 2'b00);
    chk("rst_vidas", vidas, 3'd0);
    chk("rst_invuln", invuln, 1'b0);
    chk("rst_game_over", game_over, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Start, first frame shows initial lives
    cyc(1, 0, 0, 0);
    chk("start_state", state, 2'b01);
    cyc(0, 0, 0, 1);
    chk("first_vidas", vidas, 3'd3);

    // Hit into cooldown; second hit ignored; exit after exactly 60 ticks
    cyc(0, 1, 0, 0);
    chk("hit_state", state, 2'b10);
    chk("hit_invuln", invuln, 1'b1);
    cyc(0, 0, 0, 1);
    chk("hit_vidas", vidas, 3'd2);
    cyc(0, 1, 0, 0);
    repeat (58) cyc(0, 0, 0, 1);
    chk("cd_59_state", state, 2'b10);
    cyc(0, 0, 0, 1);
    chk("cd_60_state", state, 2'b01);
    chk("cd_60_invuln", invuln, 1'b0);
    chk("cd_hit_ignored", vidas, 3'd2);

    // Start ignored in PLAY; bonus back to 3; tick coincident with hit
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("bonus_vidas", vidas, 3'd3);
    cyc(0, 1, 0, 1);
    chk("coinc_vidas", vidas, 3'd3);
    chk("coinc_state", state, 2'b10);
    cyc(0, 0, 0, 1);
    chk("coinc_next_vidas", vidas, 3'd2);
    repeat (58) cyc(0, 0, 0, 1);
    chk("coinc_59_state", state, 2'b10);
    cyc(0, 0, 0, 1);
    chk("coinc_60_state", state, 2'b01);

    // Saturation at 7, then simultaneous hit+bonus
    repeat (5) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("sat_vidas", vidas, 3'd7);
    repeat (2) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("sat_nowrap", vidas, 3'd7);
    cyc(0, 1, 1, 0);
    chk("hitbonus_state", state, 2'b10);
    cyc(0, 0, 0, 1);
    chk("hitbonus_vidas", vidas, 3'd6);

    // Drain to game over
    for (int k = 0; k < 6; k++) begin
      finish_cd();
      cyc(0, 1, 0, 0);
    end
    chk("over_state", state, 2'b11);
    chk("over_flag", game_over, 1'b1);
    cyc(0, 0, 0, 1);
    chk("over_vidas", vidas, 3'd0);
    cyc(0, 1, 1, 1);
    chk("over_ignore", state, 2'b11);
    cyc(1, 0, 0, 0);
    chk("restart_state", state, 2'b01);
    chk("restart_flag", game_over, 1'b0);
    cyc(0, 0, 0, 1);
    chk("restart_vidas", vidas, 3'd3);

    // Randomized traffic against the model
    repeat (3000) begin
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 25);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
